// File: rtl/eusci_a_baudgen_pkg.sv
// eusci_a_baudgen_pkg: shared register map, MCTLW field positions and
// encodings for the eUSCI_A baud generator.
package eusci_a_baudgen_pkg;

  localparam logic [3:0] UCAXBRW_ADDR   = 4'h6;
  localparam logic [3:0] UCAXMCTLW_ADDR = 4'h8;

  localparam int MCTLW_OS16_BIT = 0;
  localparam int MCTLW_BRF_LSB  = 4;
  localparam int MCTLW_BRF_MSB  = 7;
  localparam int MCTLW_BRS_LSB  = 8;
  localparam int MCTLW_BRS_MSB  = 15;

  typedef enum logic {
    MODE_LF   = 1'b0,
    MODE_OS16 = 1'b1
  } bg_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } bg_state_e;

  localparam logic [3:0] OS16_SAMPLE_IDX = 4'd7;
  localparam logic [3:0] OS16_LAST_IDX   = 4'd15;

  function automatic logic maj3(input logic a,
                                input logic b,
                                input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/eusci_a_baudgen_prescaler.sv
// eusci_prescaler: BRCLKen-gated down-counter with terminal count.
// The parent supplies the reload length (N or N+1) on every load.
import eusci_a_baudgen_pkg::*;

module eusci_prescaler #(
  parameter int CW = 17
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [CW-1:0] len_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o  = en_i & (cnt_q == ONE);
  assign cnt_o = cnt_q;

  // Load wins over counting; a frozen enable holds the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = len_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/eusci_a_baudgen.sv
// eusci_a_baudgen: eUSCI_A UART bit timing (bit tick, sample tick, Rx sample).
// Define EUSCI_BAUD_MAJORITY_EN for 3-point 2-of-3 majority Rx sampling.
import eusci_a_baudgen_pkg::*;

module eusci_a_baudgen #(
  parameter int BR_WIDTH = 16
) (
  input  logic                MCLK,
  input  logic                reset,
  input  logic                BRCLKen,
  input  logic [BR_WIDTH-1:0] UCBRx,
  input  logic                UCOS16,
  input  logic [3:0]          UCBRFx,
  input  logic [7:0]          UCBRSx,
  input  logic                start,
  input  logic                stop,
  input  logic                Rx,
  output logic                active,
  output logic                bitTick,
  output logic                sampleTick,
  output logic                sampleBit
);

  localparam int CW = BR_WIDTH + 1;
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  bg_state_e           state_q;
  logic [BR_WIDTH-1:0] n_q;
  logic                os16_q;
  logic [3:0]          brf_q;
  logic [7:0]          brs_q;
  logic [2:0]          k_q;
  logic [3:0]          i_q;
  logic                sample_q;

  // Length in BRCLK of OS16 period i (or of a whole LF bit) for bit k.
  function automatic logic [CW-1:0] len_of(
    input logic [BR_WIDTH-1:0] n,
    input logic                os16,
    input logic [3:0]          brf,
    input logic [7:0]          brs,
    input logic [3:0]          i,
    input logic [2:0]          k
  );
    logic [CW-1:0] len;
    len = (n == '0) ? ONE : {1'b0, n};
    if (os16) begin
      if (i < brf) len = len + ONE;
      if (i == OS16_LAST_IDX && brs[k]) len = len + ONE;
    end else if (brs[k]) begin
      len = len + ONE;
    end
    return len;
  endfunction

  logic          run;
  logic          cnt_en;
  logic          go;
  logic          tc;
  logic          bit_end;
  logic          pre_load;
  logic [3:0]    i_nx;
  logic [2:0]    k_nx;
  logic [CW-1:0] pre_len;
  logic [CW-1:0] cnt;
  logic [CW-1:0] p_cur;
  logic [CW-1:0] mid_cnt;
  logic          pt_b;
  logic          samp_val;

  assign run     = (state_q == ST_RUN);
  assign cnt_en  = run & BRCLKen & ~stop;
  assign go      = ~run & start & ~stop;
  assign bit_end = tc & (~os16_q | (i_q == OS16_LAST_IDX));
  assign i_nx    = os16_q ? i_q + 4'd1 : 4'd0;
  assign k_nx    = bit_end ? k_q + 3'd1 : k_q;

  assign pre_load = go | tc;
  assign pre_len  = go
    ? len_of(UCBRx, UCOS16, UCBRFx, UCBRSx, 4'd0, 3'd0)
    : len_of(n_q, os16_q, brf_q, brs_q, i_nx, k_nx);

  // Down-count value at which floor(P/2) BRCLK have elapsed in an LF bit.
  assign p_cur   = len_of(n_q, 1'b0, brf_q, brs_q, 4'd0, k_q);
  assign mid_cnt = p_cur - (p_cur >> 1) + ONE;

  assign pt_b = os16_q
    ? (tc & (i_q == OS16_SAMPLE_IDX))
    : (cnt_en & (cnt == mid_cnt));

  eusci_prescaler #(
    .CW(CW)
  ) u_pre (
    .clk_i (MCLK),
    .rst_i (reset),
    .load_i(pre_load),
    .en_i  (cnt_en),
    .len_i (pre_len),
    .cnt_o (cnt),
    .tc_o  (tc)
  );

`ifdef EUSCI_BAUD_MAJORITY_EN
  logic pt_a;
  logic pt_c;
  logic cap0_q;
  logic cap1_q;

  assign pt_a = os16_q
    ? (tc & (i_q == OS16_SAMPLE_IDX - 4'd1))
    : (cnt_en & (cnt == mid_cnt + ONE));
  assign pt_c = os16_q
    ? (tc & (i_q == OS16_SAMPLE_IDX + 4'd1))
    : (cnt_en & (cnt == mid_cnt - ONE));

  assign sampleTick = pt_c;
  assign samp_val   = maj3(cap0_q, cap1_q, Rx);

  // Hold the two early captures until the third point resolves the vote.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      cap0_q <= 1'b1;
      cap1_q <= 1'b1;
    end else begin
      if (pt_a) cap0_q <= Rx;
      if (pt_b) cap1_q <= Rx;
    end
  end
`else
  assign sampleTick = pt_b;
  assign samp_val   = Rx;
`endif

  assign active    = run;
  assign bitTick   = bit_end;
  assign sampleBit = sampleTick ? samp_val : sample_q;

  // Frame FSM: latch config on start, advance period/bit indices on tc.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      os16_q   <= 1'b0;
      brf_q    <= 4'd0;
      brs_q    <= 8'd0;
      k_q      <= 3'd0;
      i_q      <= 4'd0;
      sample_q <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q <= ST_RUN;
            n_q     <= UCBRx;
            os16_q  <= UCOS16;
            brf_q   <= UCBRFx;
            brs_q   <= UCBRSx;
            k_q     <= 3'd0;
            i_q     <= 4'd0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (tc) begin
            i_q <= i_nx;
            k_q <= k_nx;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (sampleTick) sample_q <= samp_val;
    end
  end

endmodule

// File: tb/tb_eusci_a_baudgen.sv
// tb_eusci_a_baudgen: randomized self-checking bench for eusci_a_baudgen.
// Expected tick positions come from per-bit BRCLK totals computed here.
module tb_eusci_a_baudgen;

`ifdef EUSCI_BAUD_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic        MCLK = 1'b0;
  logic        reset = 1'b1;
  logic        BRCLKen = 1'b0;
  logic [15:0] UCBRx = 16'd0;
  logic        UCOS16 = 1'b0;
  logic [3:0]  UCBRFx = 4'd0;
  logic [7:0]  UCBRSx = 8'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        Rx = 1'b1;
  logic        active;
  logic        bitTick;
  logic        sampleTick;
  logic        sampleBit;

  int n_checks = 0;
  int n_fail = 0;
  int tick_cyc[$];
  int samp_first;
  logic m_sb = 1'b1;

  always #5 MCLK = ~MCLK;

  eusci_a_baudgen #(.BR_WIDTH(16)) dut (
    .MCLK      (MCLK),
    .reset     (reset),
    .BRCLKen   (BRCLKen),
    .UCBRx     (UCBRx),
    .UCOS16    (UCOS16),
    .UCBRFx    (UCBRFx),
    .UCBRSx    (UCBRSx),
    .start     (start),
    .stop      (stop),
    .Rx        (Rx),
    .active    (active),
    .bitTick   (bitTick),
    .sampleTick(sampleTick),
    .sampleBit (sampleBit)
  );

  function automatic int brs_bit(input int brs, input int k);
    return (brs >> k) & 1;
  endfunction

  // BRCLK count from bit start to the end of OS16 period `upto`.
  function automatic int os16_end(input int n, input int brf, input int upto);
    int s = 0;
    for (int i = 0; i <= upto; i++) s += n + ((i < brf) ? 1 : 0);
    return s;
  endfunction

  function automatic int bit_len(input int n, input int os16, input int brf,
                                 input int brs, input int k);
    int nn = (n == 0) ? 1 : n;
    if (os16 != 0) return os16_end(nn, brf, 15) + brs_bit(brs, k);
    return nn + brs_bit(brs, k);
  endfunction

  task automatic points(input int n, input int os16, input int brf,
                        input int brs, input int k,
                        output int pa, output int pb, output int pc);
    int nn = (n == 0) ? 1 : n;
    int h;
    if (os16 != 0) begin
      pa = os16_end(nn, brf, 6);
      pb = os16_end(nn, brf, 7);
      pc = os16_end(nn, brf, 8);
    end else begin
      h = bit_len(n, 0, brf, brs, k) / 2;
      pa = h - 1;
      pb = h;
      pc = h + 1;
    end
  endtask

  // Runs one frame of nbits bits and checks every cycle against the model.
  task automatic run_frame(input string tag, input int n, input int os16,
                           input int brf, input int brs, input int nbits,
                           input int per, input int gap_at, input int gap_len,
                           input int chg_n, input int noise);
    int e = 0, bstart = 0, k = 0, blen, pa, pb, pc, sp;
    int done = 0, cyc = 0, ph = 0, budget, eb;
    logic ra = 1'b1, rb = 1'b1, ebt, est;
    budget = (nbits + 1) * bit_len(n, os16, brf, 255, 0) * per + gap_len + 100;
    tick_cyc.delete();
    samp_first = -1;
    blen = bit_len(n, os16, brf, brs, 0);
    points(n, os16, brf, brs, 0, pa, pb, pc);
    sp = MAJ ? pc : pb;
    @(posedge MCLK); #1;
    UCBRx = 16'(n); UCOS16 = (os16 != 0); UCBRFx = 4'(brf); UCBRSx = 8'(brs);
    start = 1'b1; stop = 1'b0; BRCLKen = 1'b1; Rx = 1'($urandom);
    @(negedge MCLK);
    n_checks++;
    if (active !== 1'b0 || bitTick !== 1'b0 || sampleTick !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_cycle act/bt/st got=%b%b%b exp=000",
               tag, active, bitTick, sampleTick);
    end
    while (done < nbits && cyc < budget) begin
      @(posedge MCLK); #1;
      cyc++;
      start = (noise != 0) ? 1'($urandom) : 1'b0;
      if (chg_n >= 0) UCBRx = 16'(chg_n);
      if (gap_at >= 0 && cyc >= gap_at && cyc < gap_at + gap_len) begin
        BRCLKen = 1'b0;
      end else begin
        ph++;
        BRCLKen = (ph % per == 0);
      end
      Rx = 1'($urandom);
      @(negedge MCLK);
      ebt = 1'b0;
      est = 1'b0;
      if (BRCLKen) begin
        e++;
        eb = e - bstart;
        if (eb == pa) ra = Rx;
        if (eb == pb) rb = Rx;
        if (eb == sp) begin
          est = 1'b1;
          m_sb = MAJ ? ((ra & rb) | (ra & Rx) | (rb & Rx)) : Rx;
          if (samp_first < 0) samp_first = cyc;
        end
        if (eb == blen) ebt = 1'b1;
      end
      n_checks += 4;
      if (active !== 1'b1) begin
        n_fail++;
        if (n_fail < 40) $display("FAIL %s active cyc=%0d got=%b exp=1", tag, cyc, active);
      end
      if (bitTick !== ebt) begin
        n_fail++;
        if (n_fail < 40) $display("FAIL %s bitTick cyc=%0d got=%b exp=%b", tag, cyc, bitTick, ebt);
      end
      if (sampleTick !== est) begin
        n_fail++;
        if (n_fail < 40) $display("FAIL %s sampleTick cyc=%0d got=%b exp=%b", tag, cyc, sampleTick, est);
      end
      if (sampleBit !== m_sb) begin
        n_fail++;
        if (n_fail < 40) $display("FAIL %s sampleBit cyc=%0d got=%b exp=%b", tag, cyc, sampleBit, m_sb);
      end
      if (ebt) begin
        tick_cyc.push_back(cyc);
        done++;
        bstart = e;
        k = (k + 1) % 8;
        blen = bit_len(n, os16, brf, brs, k);
        points(n, os16, brf, brs, k, pa, pb, pc);
        sp = MAJ ? pc : pb;
      end
    end
    n_checks++;
    if (done < nbits) begin
      n_fail++;
      $display("FAIL %s timeout bits got=%0d exp=%0d", tag, done, nbits);
    end
    @(posedge MCLK); #1;
    stop = 1'b1; start = 1'b0; BRCLKen = 1'b1;
    @(negedge MCLK);
    n_checks++;
    if (bitTick !== 1'b0 || sampleTick !== 1'b0) begin
      n_fail++;
      $display("FAIL %s stop_cycle bt/st got=%b%b exp=00", tag, bitTick, sampleTick);
    end
    @(posedge MCLK); #1;
    stop = 1'b0; BRCLKen = 1'b0;
    @(negedge MCLK);
    n_checks++;
    if (active !== 1'b0 || sampleBit !== m_sb) begin
      n_fail++;
      $display("FAIL %s after_stop act/sb got=%b%b exp=0%b", tag, active, sampleBit, m_sb);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge MCLK);
    #1;
    @(negedge MCLK);
    n_checks++;
    if ({active, bitTick, sampleTick, sampleBit} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset outs got=%b%b%b%b exp=0001", active, bitTick, sampleTick, sampleBit);
    end
    @(posedge MCLK); #1;
    reset = 1'b0;
    m_sb = 1'b1;
  endtask

  task automatic test_os16_mod;
    int exp_len[9] = '{104, 104, 104, 104, 104, 105, 104, 104, 104};
    int prev = 0;
    int got;
    run_frame("os16_mod", 6, 1, 8, 8'h20, 9, 1, -1, 0, -1, 0);
    for (int i = 0; i < 9; i++) begin
      got = (i < tick_cyc.size()) ? tick_cyc[i] - prev : -1;
      if (i < tick_cyc.size()) prev = tick_cyc[i];
      n_checks++;
      if (got != exp_len[i]) begin
        n_fail++;
        $display("FAIL os16_bitlen[%0d] got=%0d exp=%0d", i, got, exp_len[i]);
      end
    end
    n_checks++;
    if (samp_first != (MAJ ? 62 : 56)) begin
      n_fail++;
      $display("FAIL os16_sample_pos got=%0d exp=%0d", samp_first, MAJ ? 62 : 56);
    end
  endtask

  task automatic test_lf;
    int d0, d1;
    run_frame("lf", 104, 0, 0, 8'h01, 2, 1, -1, 0, -1, 0);
    d0 = (tick_cyc.size() > 0) ? tick_cyc[0] : -1;
    d1 = (tick_cyc.size() > 1) ? tick_cyc[1] - tick_cyc[0] : -1;
    n_checks += 3;
    if (d0 != 105) begin
      n_fail++;
      $display("FAIL lf_bit0 got=%0d exp=105", d0);
    end
    if (d1 != 104) begin
      n_fail++;
      $display("FAIL lf_bit1 got=%0d exp=104", d1);
    end
    if (samp_first != (MAJ ? 53 : 52)) begin
      n_fail++;
      $display("FAIL lf_sample_pos got=%0d exp=%0d", samp_first, MAJ ? 53 : 52);
    end
  endtask

  task automatic test_en_gating;
    int t0, t1, t2;
    run_frame("en_gate", 6, 1, 0, 0, 3, 3, 600, 50, -1, 0);
    t0 = (tick_cyc.size() > 0) ? tick_cyc[0] : -1;
    t1 = (tick_cyc.size() > 1) ? tick_cyc[1] : -1;
    t2 = (tick_cyc.size() > 2) ? tick_cyc[2] : -1;
    n_checks += 3;
    if (t0 != 288) begin
      n_fail++;
      $display("FAIL en_first_tick got=%0d exp=288", t0);
    end
    if (t1 - t0 != 288) begin
      n_fail++;
      $display("FAIL en_period got=%0d exp=288", t1 - t0);
    end
    if (t2 - t1 != 338) begin
      n_fail++;
      $display("FAIL en_gap_delay got=%0d exp=338", t2 - t1);
    end
  endtask

  task automatic test_stop_restart;
    @(posedge MCLK); #1;
    UCBRx = 16'd6; UCOS16 = 1'b1; UCBRFx = 4'd8; UCBRSx = 8'h20;
    start = 1'b1; BRCLKen = 1'b1;
    for (int c = 1; c <= 56; c++) begin
      @(posedge MCLK); #1;
      start = 1'b0;
      stop = (c == 56);
      BRCLKen = 1'b1;
      Rx = 1'($urandom);
    end
    @(negedge MCLK);
    n_checks++;
    if (bitTick !== 1'b0 || sampleTick !== 1'b0 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_mid bt/st/act got=%b%b%b exp=001", bitTick, sampleTick, active);
    end
    @(posedge MCLK); #1;
    stop = 1'b0;
    @(negedge MCLK);
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_active got=%b exp=0", active);
    end
    run_frame("restart", 6, 1, 8, 8'h20, 2, 1, -1, 0, -1, 1);
    n_checks++;
    if (tick_cyc.size() < 1 || tick_cyc[0] != 104) begin
      n_fail++;
      $display("FAIL restart_first_bit got=%0d exp=104",
               (tick_cyc.size() > 0) ? tick_cyc[0] : -1);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge MCLK); #1;
    UCBRx = 16'd6; UCOS16 = 1'b1; UCBRFx = 4'd0; UCBRSx = 8'h00;
    start = 1'b1; BRCLKen = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      @(posedge MCLK); #1;
      start = 1'b0;
      reset = (c == 31);
      Rx = 1'b0;
    end
    @(posedge MCLK); #1;
    reset = 1'b0;
    m_sb = 1'b1;
    @(negedge MCLK);
    n_checks++;
    if ({active, bitTick, sampleTick, sampleBit} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_mid outs got=%b%b%b%b exp=0001", active, bitTick, sampleTick, sampleBit);
    end
  endtask

  task automatic test_cfg_change;
    run_frame("cfg_hold", 6, 1, 0, 0, 2, 1, -1, 0, 3, 0);
    run_frame("cfg_new", 3, 1, 0, 0, 2, 1, -1, 0, -1, 0);
    n_checks++;
    if (tick_cyc.size() < 1 || tick_cyc[0] != 48) begin
      n_fail++;
      $display("FAIL cfg_new_len got=%0d exp=48",
               (tick_cyc.size() > 0) ? tick_cyc[0] : -1);
    end
  endtask

  task automatic test_random;
    int n, os16, brf, brs, per;
    for (int r = 0; r < 6; r++) begin
      os16 = r % 2;
      brs = int'($urandom_range(0, 255));
      per = int'($urandom_range(1, 2));
      if (os16 != 0) begin
        n = int'($urandom_range(0, 9));
        brf = int'($urandom_range(0, 15));
      end else begin
        n = int'($urandom_range(4, 60));
        brf = int'($urandom_range(0, 15));
      end
      run_frame("random", n, os16, brf, brs, 9, per, -1, 0, -1, 1);
    end
  endtask

  initial begin
    test_reset();
    test_os16_mod();
    test_lf();
    test_en_gating();
    test_stop_restart();
    test_reset_mid();
    test_cfg_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
